threshold_controller: RTL and testbench

THRESHOLD_CONTROLLER -- requirements
Module: threshold_controller

---
 rtl/threshold_pkg.sv | 27 ++
 rtl/threshold_edge_detector.sv | 25 ++
 rtl/threshold_controller.sv | 90 +++++++++
 tb/tb_threshold_controller.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/threshold_pkg.sv
// threshold_pkg -- shared constants for the threshold controller.
//   BTN_*     : bit positions of the buttons inside btn_db
//   STEP_*    : selectable step magnitudes
//   step_from_sw() : highest set switch picks the step, no switch gives 1
package threshold_pkg;

   localparam int BTN_CLR = 1;
   localparam int BTN_INC = 2;
   localparam int BTN_DEC = 3;

   localparam logic [8:0] STEP_1   = 9'd1;
   localparam logic [8:0] STEP_4   = 9'd4;
   localparam logic [8:0] STEP_16  = 9'd16;
   localparam logic [8:0] STEP_64  = 9'd64;
   localparam logic [8:0] STEP_256 = 9'd256;

   function automatic logic [8:0] step_from_sw(input logic [3:0] sw);
      logic [8:0] step;
      if (sw[3])      step = STEP_256;
      else if (sw[2]) step = STEP_64;
      else if (sw[1]) step = STEP_16;
      else if (sw[0]) step = STEP_4;
      else            step = STEP_1;
      return step;
   endfunction

endpackage

// File: rtl/threshold_edge_detector.sv
// edge_detector -- one-bit rising-edge detector.
//   clk   : clock, rising edge
//   reset : synchronous active-high; preloads the history with din so a level
//           already high when reset drops is not seen as an edge
//   din   : level input
//   pulse : din & ~previous din (combinational, one cycle per rising edge)
module edge_detector
   import threshold_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic pulse
);

   logic din_prev;

   always_ff @(posedge clk) begin
      if (reset) din_prev <= din;
      else       din_prev <= din;
   end

   assign pulse = din & ~din_prev;

endmodule

// File: rtl/threshold_controller.sv
// threshold_controller -- push-button adjustable signed threshold register.
//   Parameters : N_P     threshold width (>= 9 so the 256 step fits)
//                TH_INIT value loaded on reset and on clear
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   sw[3:0]    : step select, highest set switch wins (256/64/16/4, none = 1)
//   btn_db[3:0]: debounced buttons, [3]=dec [2]=inc [1]=clear [0]=unused
//   threshold  : current threshold, straight from a register
// Build option: define THR_CLEAR_EN to enable the clear button; otherwise
// btn_db[1] is ignored and no edge detector is built for it.
module threshold_controller
   import threshold_pkg::*;
#(
   parameter int N_P     = 12,
   parameter int TH_INIT = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            sw,
   input  logic [3:0]            btn_db,
   output logic signed [N_P-1:0] threshold
);

   localparam int W = N_P + 1;
   localparam logic signed [W-1:0]   SAT_MAX   = W'((2 ** (N_P - 1)) - 1);
   localparam logic signed [W-1:0]   SAT_MIN   = W'(-(2 ** (N_P - 1)));
   localparam logic signed [N_P-1:0] TH_INIT_V = N_P'(TH_INIT);

   logic inc_pulse;
   logic dec_pulse;
   logic clr_pulse;

   edge_detector u_inc (
      .clk   (clk),
      .reset (reset),
      .din   (btn_db[BTN_INC]),
      .pulse (inc_pulse)
   );

   edge_detector u_dec (
      .clk   (clk),
      .reset (reset),
      .din   (btn_db[BTN_DEC]),
      .pulse (dec_pulse)
   );

`ifdef THR_CLEAR_EN
   edge_detector u_clr (
      .clk   (clk),
      .reset (reset),
      .din   (btn_db[BTN_CLR]),
      .pulse (clr_pulse)
   );

   logic unused_btn;
   assign unused_btn = btn_db[0];
`else
   assign clr_pulse = 1'b0;

   logic unused_btn;
   assign unused_btn = &{1'b0, btn_db[1:0]};
`endif

   logic signed [W-1:0]   th_ext;
   logic signed [W-1:0]   step_ext;
   logic signed [W-1:0]   sum;
   logic signed [N_P-1:0] th_next;

   // One extra bit of headroom so the sum cannot wrap before saturation.
   assign th_ext   = {threshold[N_P-1], threshold};
   assign step_ext = W'(step_from_sw(sw));

   always_comb begin
      sum     = inc_pulse ? (th_ext + step_ext) : (th_ext - step_ext);
      th_next = threshold;
      if (clr_pulse) begin
         th_next = TH_INIT_V;
      end else if (inc_pulse != dec_pulse) begin
         if (sum > SAT_MAX)      th_next = SAT_MAX[N_P-1:0];
         else if (sum < SAT_MIN) th_next = SAT_MIN[N_P-1:0];
         else                    th_next = sum[N_P-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) threshold <= TH_INIT_V;
      else       threshold <= th_next;
   end

endmodule

// File: tb/tb_threshold_controller.sv
// tb_threshold_controller -- three controller instances (TH_INIT 0, 2040,
// -2040). Stimulus queues the expected threshold for a given cycle; a
// negedge monitor pops and compares when that cycle arrives.
module tb_threshold_controller;

   typedef struct {
      int    cyc;
      int    dut;
      int    val;
      string name;
   } exp_t;

`ifdef THR_CLEAR_EN
   localparam int CLR_EXP = 0;
`else
   localparam int CLR_EXP = 67;
`endif

   logic        clk = 1'b0;
   logic        rst [3];
   logic [3:0]  sw  [3];
   logic [3:0]  btn [3];
   logic signed [11:0] thr0, thr1, thr2;

   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   threshold_controller #(.N_P(12), .TH_INIT(0)) u_dut0 (
      .clk(clk), .reset(rst[0]), .sw(sw[0]), .btn_db(btn[0]), .threshold(thr0));
   threshold_controller #(.N_P(12), .TH_INIT(2040)) u_dut1 (
      .clk(clk), .reset(rst[1]), .sw(sw[1]), .btn_db(btn[1]), .threshold(thr1));
   threshold_controller #(.N_P(12), .TH_INIT(-2040)) u_dut2 (
      .clk(clk), .reset(rst[2]), .sw(sw[2]), .btn_db(btn[2]), .threshold(thr2));

   function automatic int get_thr(input int d);
      case (d)
         0:       return int'(thr0);
         1:       return int'(thr1);
         default: return int'(thr2);
      endcase
   endfunction

   // monitor
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         exp_t e;
         int   act;
         e   = sb_q.pop_front();
         act = get_thr(e.dut);
         checks++;
         if (e.cyc < cyc) begin
            failures++;
            $display("FAIL %s dut%0d: expectation for cycle %0d not sampled (now %0d)",
                     e.name, e.dut, e.cyc, cyc);
         end else if (act != e.val) begin
            failures++;
            $display("FAIL %s dut%0d cycle %0d: threshold=%0d expected=%0d",
                     e.name, e.dut, cyc, act, e.val);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic expect_at(input int ahead, input int d, input int v, input string nm);
      exp_t e;
      e.cyc = cyc + ahead; e.dut = d; e.val = v; e.name = nm;
      sb_q.push_back(e);
   endtask

   // Assert mask for 'hold' cycles, then release for two cycles. The new value
   // must appear one cycle after the rise and stay through hold and release.
   task automatic press(input int d, input logic [3:0] mask, input int hold,
                        input int v, input string nm);
      btn[d] = mask;
      for (int i = 1; i <= hold; i++) expect_at(i, d, v, nm);
      repeat (hold) tick();
      btn[d] = 4'b0000;
      expect_at(1, d, v, {nm, "_rel"});
      expect_at(2, d, v, {nm, "_rel"});
      repeat (2) tick();
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; sw[d] = 4'b0000; btn[d] = 4'b0000;
      end
      tick();
      for (int i = 1; i <= 3; i++) begin
         expect_at(i, 0, 0,     "reset0");
         expect_at(i, 1, 2040,  "reset1");
         expect_at(i, 2, -2040, "reset2");
      end
      repeat (3) tick();
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
      expect_at(1, 0, 0,     "post_reset0");
      expect_at(1, 1, 2040,  "post_reset1");
      expect_at(1, 2, -2040, "post_reset2");
      tick();

      // step 1 increments, then step 256
      press(0, 4'b0100, 3, 1,   "inc1_a");
      press(0, 4'b0100, 3, 2,   "inc1_b");
      sw[0] = 4'b1000;
      expect_at(1, 0, 2, "sw_change_no_edge");
      tick();
      press(0, 4'b0100, 2, 258, "inc256");

      // step 64 decrements
      sw[0] = 4'b0100;
      press(0, 4'b1000, 3, 194, "dec64_a");
      press(0, 4'b1000, 1, 130, "dec64_b");
      press(0, 4'b1000, 2, 66,  "dec64_c");

      // clear together with increment
      sw[0] = 4'b0000;
      press(0, 4'b0110, 2, CLR_EXP, "clr_with_inc");

      // simultaneous increment and decrement
      press(0, 4'b1100, 2, CLR_EXP, "inc_dec_same");
      press(0, 4'b0100, 1, CLR_EXP + 1, "inc_after");

      // button rises in the same cycle reset asserts and is held through release
      btn[0] = 4'b0100; rst[0] = 1'b1;
      expect_at(1, 0, 0, "reset_mid_press");
      expect_at(2, 0, 0, "reset_mid_press");
      repeat (2) tick();
      rst[0] = 1'b0;
      for (int i = 1; i <= 3; i++) expect_at(i, 0, 0, "held_through_reset");
      repeat (3) tick();
      btn[0] = 4'b0000;
      expect_at(1, 0, 0, "held_release");
      tick();
      press(0, 4'b0100, 1, 1, "inc_after_reset");

      // positive saturation
      sw[1] = 4'b0001;
      press(1, 4'b0100, 2, 2044, "sat_inc4");
      press(1, 4'b0100, 2, 2047, "sat_max");
      press(1, 4'b0100, 2, 2047, "sat_max_hold");
      sw[1] = 4'b1111;
      press(1, 4'b1000, 2, 1791, "dec256_prio");

      // negative saturation
      sw[2] = 4'b0010;
      press(2, 4'b1000, 2, -2048, "sat_min");
      press(2, 4'b1000, 2, -2048, "sat_min_hold");
      sw[2] = 4'b0011;
      press(2, 4'b0100, 2, -2032, "inc16_prio");

      repeat (4) tick();
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
